reg_alu_pipe: RTL and testbench
===============================

Name: reg_alu_pipe

Overview:
- Parametrised, pipelined successor to the combinational regfile+ALU datapath.
- Register read/issue is stage 1 (I); ALU, writeback mux, regfile write and PSR update are stage 2 (X).
- Includes X→I forwarding, a stall handshake, a registered PSR with per-op flag enables, and synchronous reset of all architectural state.
- Sits between the decoder/controller (drives issue fields) and the data-memory interface (supplies mem_data during X).

Parameters:
- DATA_W, 16, datapath and register width
- REG_CNT, 16, number of general registers (power of 2, ≥2)
- REG_W, $clog2(REG_CNT), register index width
- PSR_W, 5, PSR width; bit order {N,Z,F,L,C} = [4:0]

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  issue fields valid this cycle
- in_ready  out  1  = ~stall; issue accepted when in_valid & in_ready
- stall  in  1  freeze both stages (e.g. memory wait)
- write  in  1  instruction writes rdst
- imm_sel  in  1  1: ALU src operand = imm; 0: R[rsrc]
- wb_sel  in  2  0: pc1, 1: cond bit, 2: ALU result, 3: mem_data
- rsrc, rdst  in  REG_W each  source / destination register index
- alu_op  in  ALUOP_W  opcode from package
- pc1  in  DATA_W  PC+1 for link writes
- imm  in  DATA_W  immediate; imm[2:0] also selects the PSR bit for wb_sel=1
- mem_data  in  DATA_W  load data, sampled in X
- dsrc, ddst  out  DATA_W  forwarded read data for rsrc/rdst (combinational, stage I)
- wb_data  out  DATA_W  X-stage writeback value
- wb_valid  out  1  X stage holds a valid instruction
- psr  out  PSR_W  registered flags

Behaviour:
- Issue: on a clk edge with in_valid & ~stall, latch operands and control into X regs and set x_valid=1. in_valid=0 & ~stall clears x_valid. With stall=1, all X regs hold.
- Forwarding: if x_valid & x_write & ~stall & (x_rdst == rsrc or rdst), dsrc/ddst return wb_data, otherwise regfile contents. Dependent back-to-back issue therefore needs no bubble.
- ALU (combinational in X), operating on A = x_imm_sel ? x_imm : x_dsrc and B = x_ddst:
  - ADD: B+A. Sets C = carry-out, F = signed overflow.
  - SUB: B−A. Sets C = borrow, F = signed overflow.
  - CMP: compares only, result = B. Sets Z = (A==B), L = (B<A unsigned), N = (B<A signed).
  - AND, OR, XOR, NOT(A), MOV(A).
  - LSH: A[4] ? B>>|A| : B<<A[3:0], logical, zero-fill.
  - Flags not named above are unchanged. Width is DATA_W, wraps modulo 2^DATA_W.
- Writeback: wb_data = mux(x_wb_sel) over {pc1, zero-extended psr[x_imm[2:0]], ALU result, mem_data}. psr index ≥PSR_W reads 0. cond bit uses the current registered psr, i.e. before this instruction's update.
- Commit edge: x_valid & ~stall. On this edge R[x_rdst] ← wb_data if x_write, and psr flags are updated per op. No commit during stall.
- Latency: issue at edge n, committed at edge n+1; wb_valid is high for the cycle(s) between.
- Reset (synchronous, priority over all): all REG_CNT registers ← 0, psr ← 0, x_valid ← 0, X regs ← 0. An in-flight instruction is discarded with no write.
- Simultaneous issue + commit to the same register: the commit completes and the issue sees the forwarded value.
- rdst == rsrc is legal.
- in_ready has no dependency on in_valid.

Decomposition:
- Package reg_alu_pkg: ALUOP_W=4, opcode localparams (ADD, SUB, CMP, AND, OR, XOR, NOT, MOV, LSH), PSR bit indices, WB_* select constants, function flag_mask(op).
- Sub-module regfile_nrw: REG_CNT×DATA_W, 2 async reads, 1 sync write, sync reset. The ALU is a separate combinational alu_p instance.

Test Plan:
- Reset then issue MOV imm=0x1234 → r3; issue ADD r3+r3 → r4 next cycle. Expect r4=0x2468 via forwarding, wb_valid pulses, no bubble.
- ADD 0x7FFF+0x0001: wb_data=0x8000, psr.F=1, C=0. ADD 0xFFFF+0x0001: result 0, C=1.
- CMP B=0x0001, A=0xFFFF: L=1, N=0, Z=0. Then wb_sel=1 with imm[2:0]=1 writes 0x0001 to r5; ADD flags are unchanged.
- Load wb_sel=3 with stall held 3 cycles and mem_data changing: only the value on the releasing edge is written; no PSR change; in_ready=0 during stall.
- Assert reset while X holds a write to r2=0xBEEF: r2 reads 0, psr=0, wb_valid=0 next cycle.
- LSH B=0x00F0 by A=0x0014 (right 4): 0x000F. By A=0x0004: 0x0F00. Write to r(REG_CNT−1) and read back; index wrap is not permitted.

Source files
------------

// File: rtl/reg_alu_pkg.sv
// rtl/reg_alu_pkg.sv - opcodes, PSR bit positions, writeback selects and flag masks
package reg_alu_pkg;

  localparam int ALUOP_W  = 4;
  localparam int PSR_BITS = 5;

  localparam logic [ALUOP_W-1:0] OP_ADD = 4'd0;
  localparam logic [ALUOP_W-1:0] OP_SUB = 4'd1;
  localparam logic [ALUOP_W-1:0] OP_CMP = 4'd2;
  localparam logic [ALUOP_W-1:0] OP_AND = 4'd3;
  localparam logic [ALUOP_W-1:0] OP_OR  = 4'd4;
  localparam logic [ALUOP_W-1:0] OP_XOR = 4'd5;
  localparam logic [ALUOP_W-1:0] OP_NOT = 4'd6;
  localparam logic [ALUOP_W-1:0] OP_MOV = 4'd7;
  localparam logic [ALUOP_W-1:0] OP_LSH = 4'd8;

  // PSR layout {N,Z,F,L,C} = [4:0]
  localparam int PSR_C = 0;
  localparam int PSR_L = 1;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 3;
  localparam int PSR_N = 4;

  localparam logic [1:0] WB_PC   = 2'd0;
  localparam logic [1:0] WB_COND = 2'd1;
  localparam logic [1:0] WB_ALU  = 2'd2;
  localparam logic [1:0] WB_MEM  = 2'd3;

  // Which PSR bits an opcode is allowed to overwrite at commit.
  function automatic logic [PSR_BITS-1:0] flag_mask(input logic [ALUOP_W-1:0] op);
    logic [PSR_BITS-1:0] m;
    m = '0;
    case (op)
      OP_ADD, OP_SUB: begin
        m[PSR_C] = 1'b1;
        m[PSR_F] = 1'b1;
      end
      OP_CMP: begin
        m[PSR_Z] = 1'b1;
        m[PSR_L] = 1'b1;
        m[PSR_N] = 1'b1;
      end
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_p.sv
// rtl/alu_p.sv - combinational ALU producing a result and candidate PSR flags
module alu_p
  import reg_alu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [ALUOP_W-1:0]  op,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [DATA_W-1:0]   y,
  output logic [PSR_BITS-1:0] flags
);

  localparam int M = DATA_W - 1;

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // The extra top bit is carry-out for sum and borrow for diff.
  assign sum  = {1'b0, b} + {1'b0, a};
  assign diff = {1'b0, b} - {1'b0, a};

  // Result and flag candidates; the caller masks flags by opcode.
  always_comb begin
    y     = '0;
    flags = '0;
    case (op)
      OP_ADD: begin
        y            = sum[M:0];
        flags[PSR_C] = sum[DATA_W];
        flags[PSR_F] = (a[M] == b[M]) && (sum[M] != b[M]);
      end
      OP_SUB: begin
        y            = diff[M:0];
        flags[PSR_C] = diff[DATA_W];
        flags[PSR_F] = (a[M] != b[M]) && (diff[M] != b[M]);
      end
      OP_CMP: begin
        y            = b;
        flags[PSR_Z] = (a == b);
        flags[PSR_L] = (b < a);
        flags[PSR_N] = ($signed(b) < $signed(a));
      end
      OP_AND:  y = b & a;
      OP_OR:   y = b | a;
      OP_XOR:  y = b ^ a;
      OP_NOT:  y = ~a;
      OP_MOV:  y = a;
      // a[4] picks direction, a[3:0] is the distance
      OP_LSH:  y = a[4] ? (b >> a[3:0]) : (b << a[3:0]);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/regfile_nrw.sv
// rtl/regfile_nrw.sv - register file with two async read ports and one sync write port
module regfile_nrw
  import reg_alu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 16,
  parameter int REG_W   = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_W-1:0]  raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_W-1:0]  raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem_q [REG_CNT];
  logic [DATA_W-1:0] mem_d [REG_CNT];

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

  // Next-state of the array: only the addressed entry changes on a write.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Register storage; reset clears every entry.
  always_ff @(posedge clk) begin
    if (reset) mem_q <= '{default: '0};
    else       mem_q <= mem_d;
  end

endmodule

// File: rtl/reg_alu_pipe.sv
// rtl/reg_alu_pipe.sv - two-stage issue/execute regfile+ALU datapath with forwarding and PSR
module reg_alu_pipe
  import reg_alu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 16,
  parameter int REG_W   = $clog2(REG_CNT),
  parameter int PSR_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               stall,
  input  logic               write,
  input  logic               imm_sel,
  input  logic [1:0]         wb_sel,
  input  logic [REG_W-1:0]   rsrc,
  input  logic [REG_W-1:0]   rdst,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [DATA_W-1:0]  pc1,
  input  logic [DATA_W-1:0]  imm,
  input  logic [DATA_W-1:0]  mem_data,
  output logic [DATA_W-1:0]  dsrc,
  output logic [DATA_W-1:0]  ddst,
  output logic [DATA_W-1:0]  wb_data,
  output logic               wb_valid,
  output logic [PSR_W-1:0]   psr
);

  logic               x_valid_q,   x_valid_d;
  logic               x_write_q,   x_write_d;
  logic               x_imm_sel_q, x_imm_sel_d;
  logic [1:0]         x_wb_sel_q,  x_wb_sel_d;
  logic [REG_W-1:0]   x_rdst_q,    x_rdst_d;
  logic [ALUOP_W-1:0] x_alu_op_q,  x_alu_op_d;
  logic [DATA_W-1:0]  x_pc1_q,     x_pc1_d;
  logic [DATA_W-1:0]  x_imm_q,     x_imm_d;
  logic [DATA_W-1:0]  x_dsrc_q,    x_dsrc_d;
  logic [DATA_W-1:0]  x_ddst_q,    x_ddst_d;
  logic [PSR_W-1:0]   psr_q,       psr_d;

  logic [DATA_W-1:0]  rf_src, rf_dst, alu_a, alu_y;
  logic [PSR_W-1:0]   alu_flags, op_mask;
  logic [7:0]         psr_ext;
  logic               commit, cond_bit, fwd_src, fwd_dst;

  assign in_ready = ~stall;
  assign wb_valid = x_valid_q;
  assign psr      = psr_q;
  assign commit   = x_valid_q & ~stall;

  // Bypass the X result into stage I so dependent back-to-back issue needs no bubble.
  assign fwd_src = commit & x_write_q & (x_rdst_q == rsrc);
  assign fwd_dst = commit & x_write_q & (x_rdst_q == rdst);
  assign dsrc    = fwd_src ? wb_data : rf_src;
  assign ddst    = fwd_dst ? wb_data : rf_dst;

  regfile_nrw #(.DATA_W(DATA_W), .REG_CNT(REG_CNT), .REG_W(REG_W)) u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (commit & x_write_q),
    .waddr   (x_rdst_q),
    .wdata   (wb_data),
    .raddr_a (rsrc),
    .rdata_a (rf_src),
    .raddr_b (rdst),
    .rdata_b (rf_dst)
  );

  assign alu_a = x_imm_sel_q ? x_imm_q : x_dsrc_q;

  alu_p #(.DATA_W(DATA_W)) u_alu (
    .op    (x_alu_op_q),
    .a     (alu_a),
    .b     (x_ddst_q),
    .y     (alu_y),
    .flags (alu_flags)
  );

  // Zero-padding the PSR makes out-of-range condition selects read as 0.
  assign psr_ext  = 8'(psr_q);
  assign cond_bit = psr_ext[x_imm_q[2:0]];
  assign op_mask  = flag_mask(x_alu_op_q);

  // Writeback source select for the instruction in X.
  always_comb begin
    wb_data = '0;
    case (x_wb_sel_q)
      WB_PC:   wb_data = x_pc1_q;
      WB_COND: wb_data = {{(DATA_W-1){1'b0}}, cond_bit};
      WB_ALU:  wb_data = alu_y;
      WB_MEM:  wb_data = mem_data;
      default: wb_data = '0;
    endcase
  end

  // Stage I -> X latch: hold everything while stalled, otherwise take the new issue.
  always_comb begin
    x_valid_d   = x_valid_q;
    x_write_d   = x_write_q;
    x_imm_sel_d = x_imm_sel_q;
    x_wb_sel_d  = x_wb_sel_q;
    x_rdst_d    = x_rdst_q;
    x_alu_op_d  = x_alu_op_q;
    x_pc1_d     = x_pc1_q;
    x_imm_d     = x_imm_q;
    x_dsrc_d    = x_dsrc_q;
    x_ddst_d    = x_ddst_q;
    if (!stall) begin
      x_valid_d   = in_valid;
      x_write_d   = in_valid & write;
      x_imm_sel_d = imm_sel;
      x_wb_sel_d  = wb_sel;
      x_rdst_d    = rdst;
      x_alu_op_d  = alu_op;
      x_pc1_d     = pc1;
      x_imm_d     = imm;
      x_dsrc_d    = dsrc;
      x_ddst_d    = ddst;
    end
  end

  // PSR update on commit: only the bits the opcode owns change.
  always_comb begin
    psr_d = psr_q;
    if (commit) psr_d = (psr_q & ~op_mask) | (alu_flags & op_mask);
  end

  // X-stage and PSR registers; reset discards any in-flight instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_valid_q   <= 1'b0;
      x_write_q   <= 1'b0;
      x_imm_sel_q <= 1'b0;
      x_wb_sel_q  <= '0;
      x_rdst_q    <= '0;
      x_alu_op_q  <= '0;
      x_pc1_q     <= '0;
      x_imm_q     <= '0;
      x_dsrc_q    <= '0;
      x_ddst_q    <= '0;
      psr_q       <= '0;
    end else begin
      x_valid_q   <= x_valid_d;
      x_write_q   <= x_write_d;
      x_imm_sel_q <= x_imm_sel_d;
      x_wb_sel_q  <= x_wb_sel_d;
      x_rdst_q    <= x_rdst_d;
      x_alu_op_q  <= x_alu_op_d;
      x_pc1_q     <= x_pc1_d;
      x_imm_q     <= x_imm_d;
      x_dsrc_q    <= x_dsrc_d;
      x_ddst_q    <= x_ddst_d;
      psr_q       <= psr_d;
    end
  end

endmodule

// File: tb/tb_reg_alu_pipe.sv
// tb/tb_reg_alu_pipe.sv - scoreboard bench for reg_alu_pipe
module tb_reg_alu_pipe;
  import reg_alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        stall = 1'b0;
  logic        write = 1'b0;
  logic        imm_sel = 1'b0;
  logic [1:0]  wb_sel = '0;
  logic [3:0]  rsrc = '0;
  logic [3:0]  rdst = '0;
  logic [3:0]  alu_op = '0;
  logic [15:0] pc1 = 16'h0100;
  logic [15:0] imm = '0;
  logic [15:0] mem_data = '0;
  logic [15:0] dsrc, ddst, wb_data;
  logic        wb_valid;
  logic [4:0]  psr;

  typedef struct {
    logic [15:0] data;
    logic [4:0]  psr;
    string       name;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         pend_psr = 1'b0;
  logic [4:0] pend_psr_val = '0;
  string      pend_name;

  reg_alu_pipe #(.DATA_W(16), .REG_CNT(16), .REG_W(4), .PSR_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .stall    (stall),
    .write    (write),
    .imm_sel  (imm_sel),
    .wb_sel   (wb_sel),
    .rsrc     (rsrc),
    .rdst     (rdst),
    .alu_op   (alu_op),
    .pc1      (pc1),
    .imm      (imm),
    .mem_data (mem_data),
    .dsrc     (dsrc),
    .ddst     (ddst),
    .wb_data  (wb_data),
    .wb_valid (wb_valid),
    .psr      (psr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(input string name, input logic [3:0] op, input logic [1:0] ws,
                       input logic is, input logic [3:0] rs, input logic [3:0] rd,
                       input logic [15:0] iv, input logic wr,
                       input logic [15:0] ed, input logic [4:0] ep, input bit push);
    exp_t e;
    alu_op = op; wb_sel = ws; imm_sel = is; rsrc = rs; rdst = rd; imm = iv; write = wr;
    in_valid = 1'b1;
    if (push) begin
      e.data = ed; e.psr = ep; e.name = name;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic read_reg(input string name, input logic [3:0] idx, input logic [15:0] exp);
    rsrc = idx; rdst = idx;
    #1;
    check({name, "_dsrc"}, dsrc, exp);
    check({name, "_ddst"}, ddst, exp);
  endtask

  // Monitor: compare every committing writeback, then the PSR one cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend_psr = 1'b0;
      end else begin
        if (pend_psr) begin
          check({pend_name, "_psr"}, psr, pend_psr_val);
          pend_psr = 1'b0;
        end
        if (wb_valid && !stall) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_wb: got 0x%0h expected none", wb_data);
          end else begin
            e = sb_q.pop_front();
            check({e.name, "_wb"}, wb_data, e.data);
            pend_psr = 1'b1; pend_psr_val = e.psr; pend_name = e.name;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_wb_valid", wb_valid, 0);
    check("rst_psr", psr, 0);
    check("rst_in_ready", in_ready, 1);
    read_reg("rst_r3", 3, 16'h0000);

    // dependent back-to-back chain through forwarding
    issue("mov_r3", OP_MOV, WB_ALU, 1, 0, 3, 16'h1234, 1, 16'h1234, 5'h00, 1);
    issue("add_r3", OP_ADD, WB_ALU, 0, 3, 3, 16'h0000, 1, 16'h2468, 5'h00, 1);
    issue("mov_r4", OP_MOV, WB_ALU, 0, 3, 4, 16'h0000, 1, 16'h2468, 5'h00, 1);
    idle(2);
    read_reg("r3", 3, 16'h2468);
    read_reg("r4", 4, 16'h2468);

    // overflow, carry, compare, condition bits
    issue("mov_r5",    OP_MOV, WB_ALU,  1, 0, 5, 16'h7FFF, 1, 16'h7FFF, 5'h00, 1);
    issue("add_ovf",   OP_ADD, WB_ALU,  1, 0, 5, 16'h0001, 1, 16'h8000, 5'h04, 1);
    issue("mov_r6",    OP_MOV, WB_ALU,  1, 0, 6, 16'hFFFF, 1, 16'hFFFF, 5'h04, 1);
    issue("add_carry", OP_ADD, WB_ALU,  1, 0, 6, 16'h0001, 1, 16'h0000, 5'h01, 1);
    issue("mov_r7",    OP_MOV, WB_ALU,  1, 0, 7, 16'h0001, 1, 16'h0001, 5'h01, 1);
    issue("cmp_lt",    OP_CMP, WB_ALU,  1, 0, 7, 16'hFFFF, 0, 16'h0001, 5'h03, 1);
    issue("cond_l",    OP_MOV, WB_COND, 1, 0, 5, 16'h0001, 1, 16'h0001, 5'h03, 1);
    issue("cond_oob",  OP_MOV, WB_COND, 1, 0, 8, 16'h0007, 1, 16'h0000, 5'h03, 1);
    idle(2);
    read_reg("r5", 5, 16'h0001);
    read_reg("r6", 6, 16'h0000);
    read_reg("r7", 7, 16'h0001);

    // subtract with signed overflow, equality compare, xor
    issue("mov_r11", OP_MOV, WB_ALU, 1, 0, 11, 16'h8000, 1, 16'h8000, 5'h03, 1);
    issue("sub_ovf", OP_SUB, WB_ALU, 1, 0, 11, 16'h0001, 1, 16'h7FFF, 5'h06, 1);
    issue("cmp_eq",  OP_CMP, WB_ALU, 1, 0, 11, 16'h7FFF, 0, 16'h7FFF, 5'h0C, 1);
    issue("xor_r11", OP_XOR, WB_ALU, 1, 0, 11, 16'h0FF0, 1, 16'h700F, 5'h0C, 1);
    idle(2);
    read_reg("r11", 11, 16'h700F);

    // load held by a 3-cycle stall; only the releasing edge's mem_data lands
    mem_data = 16'h1111;
    issue("load_r9", OP_MOV, WB_MEM, 0, 0, 9, 16'h0000, 1, 16'hA5A5, 5'h0C, 1);
    stall = 1'b1;
    mem_data = 16'h2222;
    rsrc = 9; rdst = 9;
    #1;
    check("stall_in_ready", in_ready, 0);
    check("stall_wb_valid", wb_valid, 1);
    check("stall_no_fwd", dsrc, 16'h0000);
    repeat (3) begin
      @(posedge clk); #1;
      mem_data = mem_data + 16'h1111;
    end
    check("stall_held_r9", dsrc, 16'h0000);
    stall = 1'b0;
    mem_data = 16'hA5A5;
    @(posedge clk); #1;
    check("release_in_ready", in_ready, 1);
    read_reg("r9", 9, 16'hA5A5);

    // reset with a write to r2 still in X: nothing commits
    issue("bad_r2", OP_MOV, WB_ALU, 1, 0, 2, 16'hBEEF, 1, 16'h0000, 5'h00, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst2_wb_valid", wb_valid, 0);
    check("rst2_psr", psr, 0);
    read_reg("rst2_r2", 2, 16'h0000);
    read_reg("rst2_r9", 9, 16'h0000);

    // logical shifts, top register index
    issue("mov_r10", OP_MOV, WB_ALU, 1, 0, 10, 16'h00F0, 1, 16'h00F0, 5'h00, 1);
    issue("lsh_r",   OP_LSH, WB_ALU, 1, 0, 10, 16'h0014, 1, 16'h000F, 5'h00, 1);
    issue("mov_r15", OP_MOV, WB_ALU, 1, 0, 15, 16'h00F0, 1, 16'h00F0, 5'h00, 1);
    issue("lsh_l",   OP_LSH, WB_ALU, 1, 0, 15, 16'h0004, 1, 16'h0F00, 5'h00, 1);
    issue("pc_r12",  OP_MOV, WB_PC,  1, 0, 12, 16'h0000, 1, 16'h0100, 5'h00, 1);
    idle(2);
    read_reg("r15", 15, 16'h0F00);
    read_reg("r10", 10, 16'h000F);
    read_reg("r12", 12, 16'h0100);
    read_reg("r0",  0,  16'h0000);

    idle(3);
    check("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
